// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet winner-detect stage: default sizes,
// FSM state encoding, lane-index and iteration-count types.
package maxnet_pkg;

    localparam int W_DEF        = 32;
    localparam int MAX_ITER_DEF = 64;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] lane_idx_t;
    typedef logic [7:0] iter_cnt_t;

    localparam iter_cnt_t ITER_SAT = 8'd255;

    // Saturating increment of the iteration counter.
    function automatic iter_cnt_t iter_inc(input iter_cnt_t cnt);
        if (cnt == ITER_SAT) begin
            return cnt;
        end else begin
            return cnt + 8'd1;
        end
    endfunction

endpackage

// File: rtl/maxnet_nz_count.sv
// Combinational positive-lane counter: counts lanes with signed value > 0
// and reports the lowest such lane (0 when no lane is positive).
module maxnet_nz_count
    import maxnet_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    output logic [2:0]   pos_count,
    output lane_idx_t    first_idx
);

    logic [3:0] pos_s;

    // A lane is positive when its sign bit is clear and it is non-zero.
    always_comb begin
        pos_s[0] = ~x0[W-1] & (|x0);
        pos_s[1] = ~x1[W-1] & (|x1);
        pos_s[2] = ~x2[W-1] & (|x2);
        pos_s[3] = ~x3[W-1] & (|x3);
    end

    // Population count and lowest-index priority pick over the positive lanes.
    always_comb begin
        pos_count = {2'b00, pos_s[0]} + {2'b00, pos_s[1]}
                  + {2'b00, pos_s[2]} + {2'b00, pos_s[3]};
        if (pos_s[0]) begin
            first_idx = 2'd0;
        end else if (pos_s[1]) begin
            first_idx = 2'd1;
        end else if (pos_s[2]) begin
            first_idx = 2'd2;
        end else if (pos_s[3]) begin
            first_idx = 2'd3;
        end else begin
            first_idx = 2'd0;
        end
    end

endmodule

// File: rtl/maxnet_winner_detect.sv
// Maxnet convergence/winner stage. Captures the PLU outputs on each done
// strobe, classifies them one cycle later and either reports a winner,
// reports all-zero, or pulses `again` for another iteration.
// Optional feature macro: MAXNET_TIMEOUT_EN enables the MAX_ITER limit and
// the `timeout` outcome; without it `timeout` stays 0.
module maxnet_winner_detect
    import maxnet_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         x_valid,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] x4,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    output logic [W-1:0] out,
    output logic [1:0]   winner_idx,
    output logic         valid,
    output logic         none,
    output logic         timeout,
    output logic         again,
    output logic [7:0]   iter_count
);

    // The counter is 8 bits wide, so a limit outside 1..255 can never be hit.
    if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
        $error("maxnet_winner_detect: MAX_ITER must be within 1..255");
    end

    state_t       state_r, state_n;
    iter_cnt_t    iter_count_r, iter_count_n;
    logic [W-1:0] x_r [4];
    logic [W-1:0] x_n [4];
    logic [W-1:0] a_r [4];
    logic [W-1:0] a_n [4];
    logic [W-1:0] out_r, out_n;
    lane_idx_t    idx_r, idx_n;
    logic         valid_r, valid_n;
    logic         none_r, none_n;
    logic         timeout_r, timeout_n;
    logic         again_r, again_n;

    logic [2:0]   pos_count_s;
    lane_idx_t    first_idx_s;
    logic         timeout_hit_s;

    maxnet_nz_count #(.W(W)) u_nz_count (
        .x0        (x_r[0]),
        .x1        (x_r[1]),
        .x2        (x_r[2]),
        .x3        (x_r[3]),
        .pos_count (pos_count_s),
        .first_idx (first_idx_s)
    );

`ifdef MAXNET_TIMEOUT_EN
    // Limit reached once the counter (already bumped at capture) equals MAX_ITER.
    always_comb begin
        timeout_hit_s = (iter_count_r == iter_cnt_t'(MAX_ITER));
    end
`else
    // No iteration limit: keep iterating until at most one lane is positive.
    always_comb begin
        timeout_hit_s = 1'b0;
    end
`endif

    // Next-state and next-output logic; outputs hold unless a decision is made.
    always_comb begin
        state_n      = state_r;
        iter_count_n = iter_count_r;
        x_n          = x_r;
        a_n          = a_r;
        out_n        = out_r;
        idx_n        = idx_r;
        valid_n      = valid_r;
        none_n       = none_r;
        timeout_n    = timeout_r;
        again_n      = 1'b0;
        if (clear) begin
            state_n      = ST_RUN;
            iter_count_n = 8'd0;
            for (int i = 0; i < 4; i++) begin
                x_n[i] = {W{1'b0}};
                a_n[i] = {W{1'b0}};
            end
            out_n     = {W{1'b0}};
            idx_n     = 2'd0;
            valid_n   = 1'b0;
            none_n    = 1'b0;
            timeout_n = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (x_valid) begin
                        x_n[0] = x1;
                        x_n[1] = x2;
                        x_n[2] = x3;
                        x_n[3] = x4;
                        a_n[0] = a1;
                        a_n[1] = a2;
                        a_n[2] = a3;
                        a_n[3] = a4;
                        iter_count_n = iter_inc(iter_count_r);
                        state_n      = ST_EVAL;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_EVAL: begin
                    if (pos_count_s == 3'd1) begin
                        out_n   = a_r[first_idx_s];
                        idx_n   = first_idx_s;
                        valid_n = 1'b1;
                        state_n = ST_DONE;
                    end else if (pos_count_s == 3'd0) begin
                        out_n   = {W{1'b0}};
                        idx_n   = 2'd0;
                        none_n  = 1'b1;
                        valid_n = 1'b1;
                        state_n = ST_DONE;
                    end else if (timeout_hit_s) begin
                        out_n     = {W{1'b0}};
                        idx_n     = 2'd0;
                        timeout_n = 1'b1;
                        valid_n   = 1'b1;
                        state_n   = ST_DONE;
                    end else begin
                        again_n = 1'b1;
                        state_n = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_RUN;
                end
            endcase
        end
    end

    // State, captured data and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RUN;
            iter_count_r <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                x_r[i] <= {W{1'b0}};
                a_r[i] <= {W{1'b0}};
            end
            out_r     <= {W{1'b0}};
            idx_r     <= 2'd0;
            valid_r   <= 1'b0;
            none_r    <= 1'b0;
            timeout_r <= 1'b0;
            again_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            iter_count_r <= iter_count_n;
            x_r          <= x_n;
            a_r          <= a_n;
            out_r        <= out_n;
            idx_r        <= idx_n;
            valid_r      <= valid_n;
            none_r       <= none_n;
            timeout_r    <= timeout_n;
            again_r      <= again_n;
        end
    end

    assign out        = out_r;
    assign winner_idx = idx_r;
    assign valid      = valid_r;
    assign none       = none_r;
    assign timeout    = timeout_r;
    assign again      = again_r;
    assign iter_count = iter_count_r;

endmodule
